// File: rtl/logic_unit_pkg.sv
// Shared encodings for the logic unit: operation codes, transfer modes and
// controller states.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_ACCUM  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_OUT  = 2'b10
    } state_e;

endpackage

// File: rtl/logic_op.sv
// Combinational bitwise operator: y = a op b for AND/OR/XOR/NOR.
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_acc.sv
// Registered bitwise logic unit with valid/ready handshake, SINGLE and ACCUM
// (burst reduction) modes. Optional ZERO flag: define LOGIC_UNIT_ZERO_FLAG_EN.
module logic_unit_acc
    import logic_unit_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OP,
    input  logic             MODE,
    input  logic             LAST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic [CNT_W-1:0] COUNT,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    output logic             ZERO,
`endif
    output logic             ERR
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q,   err_d;
    op_e              op_q,    op_d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic             zero_q,  zero_d;
`endif

    logic             accept;
    logic             start_beat;
    logic             fold_beat;
    logic [CNT_W-1:0] count_inc;
    logic             hit_max;
    logic [WIDTH-1:0] lu_a;
    op_e              lu_op;
    logic [WIDTH-1:0] lu_y;

    assign IN_READY  = (state_q != ST_OUT) || OUT_READY;
    assign accept    = IN_VALID && IN_READY;
    // A beat accepted while draining OUT starts a new transfer, giving
    // back-to-back SINGLE results without a bubble.
    assign start_beat = accept && (state_q != ST_ACC);
    assign fold_beat  = accept && (state_q == ST_ACC);
    assign count_inc  = count_q + ONE_CNT;
    assign hit_max    = (count_inc == MAX_CNT);

    assign lu_a  = start_beat ? A : acc_q;
    assign lu_op = start_beat ? op_e'(OP) : op_q;

    logic_op #(
        .WIDTH (WIDTH)
    ) u_logic_op (
        .a  (lu_a),
        .b  (B),
        .op (lu_op),
        .y  (lu_y)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        err_d   = err_q;
        op_d    = op_q;

        if (start_beat) begin
            acc_d   = lu_y;
            count_d = ONE_CNT;
            err_d   = 1'b0;
            op_d    = op_e'(OP);
            if ((mode_e'(MODE) == MODE_SINGLE) || LAST) begin
                state_d = ST_OUT;
            end else begin
                state_d = ST_ACC;
            end
        end else if (fold_beat) begin
            acc_d   = lu_y;
            count_d = count_inc;
            if (LAST || hit_max) begin
                state_d = ST_OUT;
                err_d   = !LAST;
            end
        end else if ((state_q == ST_OUT) && OUT_READY) begin
            state_d = ST_IDLE;
        end
    end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    // The flag tracks the value actually loaded into the result register.
    always_comb begin
        zero_d = zero_q;
        if (start_beat || fold_beat) begin
            zero_d = (lu_y == '0);
        end
    end
`endif

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RESET) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            op_q    <= OP_AND;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            err_q   <= err_d;
            op_q    <= op_d;
        end
    end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign ZERO = zero_q;
`endif

    assign OUT_VALID = (state_q == ST_OUT);
    assign RESULT    = acc_q;
    assign COUNT     = count_q;
    assign ERR       = err_q;

endmodule
